// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared types and constants for the full-clock time-keeping slice.
//   - state_t   : controller mode encoding (RUN / SET_HR / SET_MIN)
//   - BCD_*     : two-digit BCD limit constants used by the digit chain
//   - bcd_inc() : +1 on a two-digit BCD value (ones wrap 9 -> 0 into tens)
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  // Wrap-to-minimum is handled by the caller; this only steps the digits.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
//   Two-digit BCD counter running MIN_VAL..MAX_VAL, used for sec, min and hr.
//   Ports:
//     clk   in  1  rising-edge clock
//     rst   in  1  synchronous active-high reset, loads RST_VAL
//     inc   in  1  step by one (MAX_VAL wraps to MIN_VAL)
//     clr   in  1  load MIN_VAL, has priority over inc
//     q     out 8  [7:4] tens, [3:0] ones
//     wrap  out 1  combinational carry: inc while at MAX_VAL
// -----------------------------------------------------------------------------
module bcd2_counter #(
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] MAX_VAL = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       wrap
);
  import clock_pkg::*;

  // Full 8-bit compare against the limit; the carry is combinational so a
  // whole sec->min->hr ripple lands on one clock edge.
  assign wrap = inc & ~clr & (q == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (clr)
      q <= MIN_VAL;
    else if (inc)
      q <= (q == MAX_VAL) ? MIN_VAL : bcd_inc(q);
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// -----------------------------------------------------------------------------
// clock_time_ctrl
//   Time-keeping and time-set controller: 1 Hz prescaler, BCD sec/min/hr chain,
//   button-driven RUN -> SET_HR -> SET_MIN mode machine and blink strobes.
//   Optional macro HOUR12_EN selects a 12-hour display (12,01..11) with pm.
//   Ports:
//     clk       in  1  board clock
//     rst       in  1  synchronous active-high reset
//     btn_mode  in  1  debounced async level, rising edge = mode step
//     btn_inc   in  1  debounced async level, rising edge = field increment
//     sec_bcd   out 8  seconds 00..59
//     min_bcd   out 8  minutes 00..59
//     hr_bcd    out 8  hours 00..23 (01..12 with HOUR12_EN)
//     set_mode  out 2  0 RUN, 1 SET_HR, 2 SET_MIN
//     blank_hr  out 1  blank hour digits
//     blank_min out 1  blank minute digits
//     tick      out 1  one-cycle 1 Hz pulse
//     pm        out 1  PM indicator (0 without HOUR12_EN)
// -----------------------------------------------------------------------------
module clock_time_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic [1:0] set_mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       tick,
  output logic       pm
);
  import clock_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

`ifdef HOUR12_EN
  localparam logic [7:0] HR_MIN = BCD_01;
  localparam logic [7:0] HR_MAX = BCD_12;
  localparam logic [7:0] HR_RST = BCD_12;
`else
  localparam logic [7:0] HR_MIN = BCD_00;
  localparam logic [7:0] HR_MAX = BCD_23;
  localparam logic [7:0] HR_RST = BCD_00;
`endif

  logic [2:0]    mode_sync, inc_sync;
  logic          mode_pulse, inc_pulse, inc_ok;
  state_t        state_q, state_d;
  logic          in_run, in_set_hr, in_set_min, set_exit;
  logic [PW-1:0] presc_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          sec_wrap, min_wrap, hr_wrap_unused;
  logic          min_inc, hr_inc;

  // Two synchronizer flops plus one history flop per button; bit 0 is s1.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sync <= 3'b000;
      inc_sync  <= 3'b000;
    end else begin
      mode_sync <= {mode_sync[1:0], btn_mode};
      inc_sync  <= {inc_sync[1:0], btn_inc};
    end
  end

  assign mode_pulse = mode_sync[1] & ~mode_sync[2];
  assign inc_pulse  = inc_sync[1] & ~inc_sync[2];
  // A mode step in the same cycle swallows the increment.
  assign inc_ok     = inc_pulse & ~mode_pulse;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Mode sequencing; the unused encoding falls back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_pulse) state_d = SET_HR;
      SET_HR:  if (mode_pulse) state_d = SET_MIN;
      SET_MIN: if (mode_pulse) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign in_run     = (state_q == RUN);
  assign in_set_hr  = (state_q == SET_HR);
  assign in_set_min = (state_q == SET_MIN);
  assign set_exit   = in_set_min & mode_pulse;
  assign set_mode   = state_q;

  // The prescaler is parked at 0 while hours are edited and restarted when
  // leaving SET_MIN, so the first second after a time-set is a full one.
  // It keeps counting in SET_MIN, but ticks only take effect in RUN.
  always_ff @(posedge clk) begin
    if (rst)
      presc_q <= '0;
    else if (in_set_hr || set_exit || presc_q == TICK_LAST)
      presc_q <= '0;
    else
      presc_q <= presc_q + PW'(1);
  end

  assign tick = in_run & (presc_q == TICK_LAST);

  // Carries into hr only come from a full sec+min rollover, never from a
  // minute increment made in SET_MIN.
  assign min_inc = sec_wrap | (in_set_min & inc_ok);
  assign hr_inc  = (sec_wrap & min_wrap) | (in_set_hr & inc_ok);

  bcd2_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_sec (
    .clk(clk), .rst(rst), .inc(tick), .clr(set_exit), .q(sec_bcd), .wrap(sec_wrap)
  );

  bcd2_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0), .q(min_bcd), .wrap(min_wrap)
  );

  bcd2_counter #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0), .q(hr_bcd), .wrap(hr_wrap_unused)
  );

`ifdef HOUR12_EN
  logic pm_q;

  // pm flips on the 11 -> 12 step only, whether it comes from a carry or
  // from an edit increment.
  always_ff @(posedge clk) begin
    if (rst)
      pm_q <= 1'b0;
    else if (hr_inc && hr_bcd == BCD_11)
      pm_q <= ~pm_q;
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  // Free-running blink divider, independent of mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_hr  <= 1'b0;
      blank_min <= 1'b0;
    end else begin
      blank_hr  <= in_set_hr & blink_phase;
      blank_min <= in_set_min & blink_phase;
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_time_ctrl
//   Randomized and directed stimulus for clock_time_ctrl (TICK_DIV = 10,
//   BLINK_DIV = 4) against a reference model that keeps time of day as a
//   plain seconds count and derives BCD, mode and blink from arithmetic.
// -----------------------------------------------------------------------------
module tb_clock_time_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 4;

`ifdef HOUR12_EN
  localparam logic [7:0] HR_MIDNIGHT = 8'h12;
`else
  localparam logic [7:0] HR_MIDNIGHT = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_inc;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic [1:0] set_mode;
  logic       blank_hr, blank_min, tick, pm;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;

  // Reference model state
  int m_mode;
  int m_time;
  int m_cnt;
  int m_edges;
  bit m_blank_hr, m_blank_min;
  bit mh1, mh2, mh3, ih1, ih2, ih3;

  always #5 clk = ~clk;

  clock_time_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
    .set_mode(set_mode), .blank_hr(blank_hr), .blank_min(blank_min),
    .tick(tick), .pm(pm)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int m_hr();
    return m_time / 3600;
  endfunction

  function automatic logic [7:0] exp_hr();
`ifdef HOUR12_EN
    int h12;
    h12 = m_hr() % 12;
    if (h12 == 0) h12 = 12;
    return to_bcd(h12);
`else
    return to_bcd(m_hr());
`endif
  endfunction

  function automatic bit exp_pm();
`ifdef HOUR12_EN
    return (m_hr() >= 12);
`else
    return 1'b0;
`endif
  endfunction

  // One rising clock edge of the reference model. A button level that first
  // reads high at edge n acts at edge n+2 (plus the one of sampling = 3rd edge).
  function automatic void model_edge(input bit r, input bit bm, input bit bi);
    bit mp, ip, phase;
    int old_mode, h, mi, s;
    if (r) begin
      m_mode = 0; m_time = 0; m_cnt = 0; m_edges = 0;
      m_blank_hr = 0; m_blank_min = 0;
      mh1 = 0; mh2 = 0; mh3 = 0; ih1 = 0; ih2 = 0; ih3 = 0;
      return;
    end
    mp = mh2 & ~mh3;
    ip = ih2 & ~ih3;
    mh3 = mh2; mh2 = mh1; mh1 = bm;
    ih3 = ih2; ih2 = ih1; ih1 = bi;
    old_mode = m_mode;
    phase = ((m_edges / BLINK_DIV) % 2) == 1;
    m_blank_hr  = (old_mode == 1) && phase;
    m_blank_min = (old_mode == 2) && phase;
    if (old_mode == 0 && m_cnt == TICK_DIV - 1)
      m_time = (m_time + 1) % 86400;
    h  = m_time / 3600;
    mi = (m_time / 60) % 60;
    s  = m_time % 60;
    if (mp) begin
      if (old_mode == 2) s = 0;
      m_mode = (old_mode + 1) % 3;
    end else if (ip) begin
      if (old_mode == 1) h = (h + 1) % 24;
      else if (old_mode == 2) mi = (mi + 1) % 60;
    end
    m_time = h * 3600 + mi * 60 + s;
    if (old_mode == 1 || (mp && old_mode == 2))
      m_cnt = 0;
    else
      m_cnt = (m_cnt + 1) % TICK_DIV;
    m_edges++;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("sec",       32'(sec_bcd),   32'(to_bcd(m_time % 60)));
    checkOutput("min",       32'(min_bcd),   32'(to_bcd((m_time / 60) % 60)));
    checkOutput("hr",        32'(hr_bcd),    32'(exp_hr()));
    checkOutput("set_mode",  32'(set_mode),  32'(m_mode));
    checkOutput("blank_hr",  32'(blank_hr),  32'(m_blank_hr));
    checkOutput("blank_min", 32'(blank_min), 32'(m_blank_min));
    checkOutput("tick",      32'(tick),      32'(m_mode == 0 && m_cnt == TICK_DIV - 1));
    checkOutput("pm",        32'(pm),        32'(exp_pm()));
  endtask

  // Drive inputs for one cycle (called at a falling edge), step model on the
  // rising edge, compare everything at the next falling edge.
  task automatic applyStimulus(input bit r, input bit bm, input bit bi);
    rst = r; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_edge(r, bm, bi);
    @(negedge clk);
    checkAll();
    if (tick === 1'b1) tick_seen++;
  endtask

  task automatic pressButton(input bit is_mode, input bit is_inc);
    int hold, gap;
    hold = $urandom_range(1, 3);
    gap  = $urandom_range(3, 5);
    for (int i = 0; i < hold; i++) applyStimulus(1'b0, is_mode, is_inc);
    for (int i = 0; i < gap; i++)  applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyclesToFirstSecond(input string tag);
    int n;
    n = 0;
    while (sec_bcd !== 8'h01 && n < 40) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput(tag, 32'(n), 32'd10);
  endtask

  initial begin
    int n, trans;
    bit prev, bm, bi, r;
    logic [7:0] hr_before;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_sec",  32'(sec_bcd),  32'h00);
    checkOutput("rst_min",  32'(min_bcd),  32'h00);
    checkOutput("rst_hr",   32'(hr_bcd),   32'(HR_MIDNIGHT));
    checkOutput("rst_mode", 32'(set_mode), 32'd0);
    checkOutput("rst_tick", 32'(tick),     32'd0);
    checkOutput("rst_pm",   32'(pm),       32'd0);

    // 600 cycles of running time
    tick_seen = 0;
    for (int i = 0; i < 600; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run_ticks", 32'(tick_seen), 32'd60);
    checkOutput("run_sec",   32'(sec_bcd),   32'h00);
    checkOutput("run_min",   32'(min_bcd),   32'h01);
    checkOutput("run_hr",    32'(hr_bcd),    32'(HR_MIDNIGHT));

    // Set 23:59 and roll over through midnight
    pressButton(1'b1, 1'b0);
    n = (23 - m_hr() + 24) % 24;
    for (int i = 0; i < n; i++) pressButton(1'b0, 1'b1);
    pressButton(1'b1, 1'b0);
    n = (59 - (m_time / 60) % 60 + 60) % 60;
    for (int i = 0; i < n; i++) pressButton(1'b0, 1'b1);
    pressButton(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midnight_sec", 32'(sec_bcd), 32'h00);
    checkOutput("midnight_min", 32'(min_bcd), 32'h00);
    checkOutput("midnight_hr",  32'(hr_bcd),  32'(HR_MIDNIGHT));

    // Mode walk and exit timing
    for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    pressButton(1'b1, 1'b0);
    checkOutput("walk_mode1", 32'(set_mode), 32'd1);
    pressButton(1'b1, 1'b0);
    checkOutput("walk_mode2", 32'(set_mode), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (set_mode !== 2'd0 && n < 8) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("walk_mode0", 32'(set_mode), 32'd0);
    checkOutput("exit_sec_clear", 32'(sec_bcd), 32'h00);
    cyclesToFirstSecond("exit_first_tick");

    // Blink in SET_HR, then simultaneous mode+inc
    pressButton(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    prev = blank_hr;
    trans = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (blank_hr !== prev) trans++;
      prev = blank_hr;
    end
    checkOutput("blank_hr_toggles", 32'(trans), 32'd4);
    hr_before = exp_hr();
    pressButton(1'b1, 1'b1);
    checkOutput("mode_wins_state", 32'(set_mode), 32'd2);
    checkOutput("mode_wins_hr",    32'(hr_bcd),   32'(hr_before));

    // Reset mid-count in SET_MIN
    n = 0;
    while (m_cnt != 7 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("presc_at_7", 32'(m_cnt), 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("mrst_sec",   32'(sec_bcd),   32'h00);
    checkOutput("mrst_min",   32'(min_bcd),   32'h00);
    checkOutput("mrst_hr",    32'(hr_bcd),    32'(HR_MIDNIGHT));
    checkOutput("mrst_mode",  32'(set_mode),  32'd0);
    checkOutput("mrst_blank", 32'({blank_hr, blank_min}), 32'd0);
    cyclesToFirstSecond("mrst_first_tick");

    // Random button traffic with occasional resets
    bm = 1'b0; bi = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 11) == 0) bm = ~bm;
      if ($urandom_range(0, 2) == 0)  bi = ~bi;
      applyStimulus(r, bm, bi);
    end

`ifdef HOUR12_EN
    // 12-hour pm behaviour around 11 -> 12 -> 01
    applyStimulus(1'b1, 1'b0, 1'b0);
    pressButton(1'b1, 1'b0);
    n = (11 - m_hr() + 24) % 24;
    for (int i = 0; i < n; i++) pressButton(1'b0, 1'b1);
    checkOutput("h12_hr11", 32'(hr_bcd), 32'h11);
    checkOutput("h12_pm0",  32'(pm),     32'd0);
    pressButton(1'b0, 1'b1);
    checkOutput("h12_hr12", 32'(hr_bcd), 32'h12);
    checkOutput("h12_pm1",  32'(pm),     32'd1);
    pressButton(1'b0, 1'b1);
    checkOutput("h12_hr01", 32'(hr_bcd), 32'h01);
    checkOutput("h12_pm1b", 32'(pm),     32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
